// File: rtl/tm_mul_scheduler.sv
// Round-robin front end that time-shares one external combinational multiplier
// among N_REQ requesters, with a credit-guarded in-order result FIFO.
module tm_mul_scheduler #(
    parameter int N_REQ      = 4,
    parameter int W          = 8,
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*W-1:0]       rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic [15:0]          op_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = 2 * W;

    logic [IDW-1:0] r_rr;
    logic [W-1:0]   r_mul_a, r_mul_b;
    logic [LAT-1:0] r_tok_v;
    logic [IDW-1:0] r_tok_id [LAT];
    logic [PW-1:0]  r_mem_d  [FIFO_DEPTH];
    logic [IDW-1:0] r_mem_id [FIFO_DEPTH];
    logic [AW-1:0]  r_wr, r_rd;
    logic [CW-1:0]  r_fifo_cnt;
    logic           r_rsp_valid;
    logic [PW-1:0]  r_rsp_data;
    logic [IDW-1:0] r_rsp_id;
    logic [15:0]    r_op_cnt;

    logic [CW-1:0]    w_inflight;
    logic             w_issue_ok, w_found, w_accept, w_push, w_pop, w_head_from_push;
    logic [IDW-1:0]   w_grant, w_push_id, w_head_id;
    logic [N_REQ-1:0] w_ready;
    logic [PW-1:0]    w_push_d, w_head_d;
    logic [CW-1:0]    w_cnt_nxt;
    logic [AW-1:0]    w_rd_nxt;

    always_comb begin
        w_inflight = '0;
        for (int unsigned s = 0; s < LAT; s++)
            w_inflight = w_inflight + CW'(r_tok_v[s]);
    end

    // Credit counts everything already accepted and not yet popped; registered terms only.
    assign w_issue_ok = ({1'b0, r_fifo_cnt} + {1'b0, w_inflight}) < (CW+1)'(FIFO_DEPTH);

    always_comb begin : p_arb
        logic [IDW:0] sum;
        sum     = '0;
        w_found = 1'b0;
        w_grant = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            sum = {1'b0, r_rr} + (IDW+1)'(off);
            if (sum >= (IDW+1)'(N_REQ))
                sum = sum - (IDW+1)'(N_REQ);
            if (!w_found && req_valid[sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_grant = sum[IDW-1:0];
            end
        end
    end

    assign w_accept = w_found & w_issue_ok & rst_n;

    always_comb begin
        w_ready = '0;
        if (w_accept)
            w_ready[w_grant] = 1'b1;
    end

    assign w_push    = r_tok_v[LAT-1];
    assign w_push_id = r_tok_id[LAT-1];

    if (LAT == 1) begin : g_lat1
        assign w_push_d = mul_p;
    end else begin : g_latn
        logic [PW-1:0] r_d [LAT-1];   // r_d[j] holds the product of pipeline stage j+2

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned j = 0; j < LAT - 1; j++)
                    r_d[j] <= '0;
            end else begin
                r_d[0] <= mul_p;
                for (int unsigned j = 1; j < LAT - 1; j++)
                    r_d[j] <= r_d[j-1];
            end
        end

        assign w_push_d = r_d[LAT-2];
    end

    assign w_pop     = r_rsp_valid & rsp_ready;
    assign w_rd_nxt  = r_rd + AW'(w_pop);
    assign w_cnt_nxt = r_fifo_cnt + CW'(w_push) - CW'(w_pop);
    // An entry pushed into a FIFO that is empty after this pop becomes the head directly.
    assign w_head_from_push = w_push && ((r_fifo_cnt - CW'(w_pop)) == '0);
    assign w_head_d  = w_head_from_push ? w_push_d  : r_mem_d[w_rd_nxt];
    assign w_head_id = w_head_from_push ? w_push_id : r_mem_id[w_rd_nxt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_op_cnt    <= '0;
            r_tok_v     <= '0;
            for (int unsigned s = 0; s < LAT; s++)
                r_tok_id[s] <= '0;
            for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                r_mem_d[e]  <= '0;
                r_mem_id[e] <= '0;
            end
            r_wr        <= '0;
            r_rd        <= '0;
            r_fifo_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            if (w_accept) begin
                r_mul_a <= req_a[w_grant*W +: W];
                r_mul_b <= req_b[w_grant*W +: W];
                r_rr    <= (w_grant == IDW'(N_REQ - 1)) ? '0 : w_grant + 1'b1;
                if (r_op_cnt != 16'hFFFF)
                    r_op_cnt <= r_op_cnt + 16'd1;
            end

            r_tok_v[0]  <= w_accept;
            r_tok_id[0] <= w_grant;
            for (int unsigned s = 1; s < LAT; s++) begin
                r_tok_v[s]  <= r_tok_v[s-1];
                r_tok_id[s] <= r_tok_id[s-1];
            end

            if (w_push) begin
                r_mem_d[r_wr]  <= w_push_d;
                r_mem_id[r_wr] <= w_push_id;
                r_wr           <= r_wr + 1'b1;
            end
            r_rd        <= w_rd_nxt;
            r_fifo_cnt  <= w_cnt_nxt;
            r_rsp_valid <= (w_cnt_nxt != '0);
            if (w_cnt_nxt != '0) begin
                r_rsp_data <= w_head_d;
                r_rsp_id   <= w_head_id;
            end
        end
    end

    assign req_ready = w_ready;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = (w_inflight != '0) | (r_fifo_cnt != '0);
    assign op_count  = r_op_cnt;

endmodule

// File: tb/tb_tm_mul_scheduler.sv
// Bench for tm_mul_scheduler: a LAT=1 and a LAT=3 instance share stimulus and are
// each compared every cycle against a queue-based model of outstanding operations.
module tb_tm_mul_scheduler;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int QS    = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_ready;
    logic           trunc_mode;

    logic [N-1:0]   req_ready [2];
    logic [W-1:0]   mul_a     [2];
    logic [W-1:0]   mul_b     [2];
    logic [2*W-1:0] mul_p     [2];
    logic           rsp_valid [2];
    logic [2*W-1:0] rsp_data  [2];
    logic [1:0]     rsp_id    [2];
    logic           busy      [2];
    logic [15:0]    op_count  [2];

    // Stand-in for the k=7 truncated multiplier: each operand loses its 7 LSBs.
    function automatic logic [15:0] ref_mul(input logic mode, input logic [7:0] a, input logic [7:0] b);
        return mode ? {1'b0, a[7] & b[7], 14'b0} : 16'(a) * 16'(b);
    endfunction

    assign mul_p[0] = ref_mul(trunc_mode, mul_a[0], mul_b[0]);
    assign mul_p[1] = ref_mul(trunc_mode, mul_a[1], mul_b[1]);

    tm_mul_scheduler #(.N_REQ(N), .W(W), .LAT(1), .FIFO_DEPTH(DEPTH)) u_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mul_p[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]),
        .rsp_id(rsp_id[0]), .busy(busy[0]), .op_count(op_count[0]));

    tm_mul_scheduler #(.N_REQ(N), .W(W), .LAT(3), .FIFO_DEPTH(DEPTH)) u_l3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mul_p[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]),
        .rsp_id(rsp_id[1]), .busy(busy[1]), .op_count(op_count[1]));

    int n_tests = 0;
    int n_fail  = 0;

    // Model: every accepted op sits in q_* from accept until pop, stamped with its accept edge.
    int          m_rr  [2];
    int          m_opc [2];
    logic [7:0]  m_ma  [2];
    logic [7:0]  m_mb  [2];
    logic [15:0] q_d   [2][QS];
    int          q_id  [2][QS];
    longint      q_e   [2][QS];
    int          q_h   [2];
    int          q_t   [2];
    longint      n_edge = 0;
    bit          p_acc [2];
    bit          p_pop [2];
    int          p_g   [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rr[k] = 0; m_opc[k] = 0; m_ma[k] = '0; m_mb[k] = '0;
            q_h[k] = 0; q_t[k] = 0; p_acc[k] = 1'b0; p_pop[k] = 1'b0; p_g[k] = 0;
        end
    endtask

    task automatic check_inst(input int k);
        int          outst, lat, g, fc, fc_dut;
        bit          ok, found, ev;
        logic [N-1:0] er;
        string       p;
        p     = (k == 0) ? "L1 " : "L3 ";
        lat   = (k == 0) ? 1 : 3;
        outst = q_t[k] - q_h[k];
        ok    = (rst_n === 1'b1) && (outst < DEPTH);
        found = 1'b0;
        g     = 0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (m_rr[k] + i) % N;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                g = idx;
            end
        end
        er = '0;
        if (ok && found) er[g] = 1'b1;
        ev = (outst > 0) && (q_e[k][q_h[k] % QS] + lat <= n_edge);
        fc = 0;
        for (int j = q_h[k]; j < q_t[k]; j++)
            if (q_e[k][j % QS] + lat <= n_edge) fc++;
        fc_dut = (k == 0) ? int'(u_l1.r_fifo_cnt) : int'(u_l3.r_fifo_cnt);

        chk({p, "req_ready"}, req_ready[k], er);
        chk({p, "mul_a"}, mul_a[k], m_ma[k]);
        chk({p, "mul_b"}, mul_b[k], m_mb[k]);
        chk({p, "rsp_valid"}, rsp_valid[k], ev);
        chk({p, "busy"}, busy[k], outst > 0);
        chk({p, "op_count"}, op_count[k], m_opc[k]);
        chk({p, "fifo_count"}, fc_dut, fc);
        if (ev) begin
            chk({p, "rsp_data"}, rsp_data[k], q_d[k][q_h[k] % QS]);
            chk({p, "rsp_id"}, rsp_id[k], q_id[k][q_h[k] % QS]);
        end
        p_acc[k] = (er != '0);
        p_g[k]   = g;
        p_pop[k] = ev && rsp_ready;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (p_pop[k]) q_h[k]++;
            if (p_acc[k]) begin
                int g;
                g = p_g[k];
                m_ma[k] = req_a[g*W +: W];
                m_mb[k] = req_b[g*W +: W];
                q_d[k][q_t[k] % QS]  = ref_mul(trunc_mode, m_ma[k], m_mb[k]);
                q_id[k][q_t[k] % QS] = g;
                q_e[k][q_t[k] % QS]  = n_edge + 1;
                q_t[k]++;
                m_rr[k] = (g + 1) % N;
                if (m_opc[k] < 16'hFFFF) m_opc[k]++;
            end
        end
        n_edge++;
    endtask

    // Called at the falling edge with inputs already driven.
    task automatic step();
        #1;
        check_inst(0);
        check_inst(1);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rand_ops();
        req_a = $urandom;
        req_b = $urandom;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        trunc_mode = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        rst_n      = 1'b0;
        model_reset();
        @(negedge clk);

        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle rsp_data", rsp_data[0], 16'h0);
        chk("idle rsp_id", rsp_id[0], 2'd0);
        chk("idle busy", busy[0], 1'b0);

        // Single ops from requester 2 through the truncated multiplier.
        trunc_mode = 1'b1;
        req_valid  = 4'b0100;
        req_a      = 32'h00FF_0000;
        req_b      = 32'h00FF_0000;
        step();
        req_valid = '0;
        chk("single rsp_valid E", rsp_valid[0], 1'b0);
        chk("single mul_a", mul_a[0], 8'hFF);
        step();
        chk("single rsp_valid E+1", rsp_valid[0], 1'b1);
        chk("single rsp_data", rsp_data[0], 16'h4000);
        chk("single rsp_id", rsp_id[0], 2'd2);
        chk("single op_count", op_count[0], 16'd1);
        req_valid = 4'b0100;
        req_a     = 32'h0080_0000;
        req_b     = 32'h007F_0000;
        step();
        req_valid = '0;
        step();
        chk("single2 rsp_valid", rsp_valid[0], 1'b1);
        chk("single2 rsp_data", rsp_data[0], 16'h0000);
        chk("single2 op_count", op_count[0], 16'd2);
        repeat (6) step();
        trunc_mode = 1'b0;

        // Fairness: pointer sits at 3 after the last grant to requester 2.
        req_valid = 4'hF;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            #1;
            chk("fair grant", req_ready[0], 4'b0001 << ((3 + i) % 4));
            step();
        end
        req_valid = '0;
        repeat (6) step();

        // Backpressure: only FIFO_DEPTH accepts with the consumer stalled.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            #1;
            if (req_ready[0][0]) acc++;
            step();
        end
        chk("bp accepts", acc, DEPTH);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) step();
        req_valid = 4'b0001;
        repeat (3) begin rand_ops(); step(); end
        req_valid = '0;
        repeat (6) step();

        // Random traffic: alternating then random consumer readiness.
        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom);
            rand_ops();
            rsp_ready = (i < 200) ? 1'(i % 2) : 1'($urandom);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) step();

        // Saturation of op_count.
        req_valid = 4'hF;
        for (int i = 0; i < 70000 && m_opc[0] < 16'hFFFE; i++) begin
            rand_ops();
            step();
        end
        chk("sat preload", op_count[0], 16'hFFFE);
        repeat (3) begin rand_ops(); step(); end
        chk("sat op_count", op_count[0], 16'hFFFF);
        req_valid = '0;
        repeat (6) step();

        // Asynchronous reset with ops outstanding.
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        repeat (2) begin rand_ops(); step(); end
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_inst(0);
        check_inst(1);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        repeat (2) step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) step();
        chk("rst rsp_valid L1", rsp_valid[0], 1'b0);
        chk("rst rsp_valid L3", rsp_valid[1], 1'b0);
        chk("rst rsp_data", rsp_data[0], 16'h0);
        req_valid = 4'b1010;
        rand_ops();
        #1;
        chk("rst first grant", req_ready[0], 4'b0010);
        step();
        req_valid = '0;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
